decoder_n_pulse: RTL and testbench



---
 rtl/decoder_n_pulse_pkg.sv | 17 +
 rtl/decoder_n_pulse_if.sv | 26 ++
 rtl/decoder_n_pulse_hold_cnt.sv | 31 +++
 rtl/decoder_n_pulse.sv | 91 +++++++++
 tb/tb_decoder_n_pulse.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/decoder_n_pulse_pkg.sv
// Shared types and helpers for the one-hot pulse decoder.
// Holds the FSM state encoding and the hold-counter width function.
package decoder_pkg;

   typedef enum logic {
      DEC_IDLE   = 1'b0,
      DEC_ACTIVE = 1'b1
   } dec_state_t;

   // Counter must hold HOLD-1 down to zero; never narrower than one bit.
   function automatic int cnt_width(input int hold);
      int w;
      w = $clog2(hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/decoder_n_pulse_if.sv
// Handshake and strobe bundle for decoder_n_pulse.
// The err line exists only when DEC_RANGE_CHECK_EN is defined.
interface decoder_n_pulse_if #(
   parameter int SEL_W = 2,
   parameter int OUT_N = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic [OUT_N-1:0] y;
   logic             busy;
   logic             done;
`ifdef DEC_RANGE_CHECK_EN
   logic             err;

   modport master (output in_valid, output sel,
                   input in_ready, input y, input busy, input done, input err);
   modport slave  (input in_valid, input sel,
                   output in_ready, output y, output busy, output done, output err);
`else
   modport master (output in_valid, output sel,
                   input in_ready, input y, input busy, input done);
   modport slave  (input in_valid, input sel,
                   output in_ready, output y, output busy, output done);
`endif
endinterface

// File: rtl/decoder_n_pulse_hold_cnt.sv
// Loadable hold-time down-counter with a zero flag (module decoder_hold_cnt).
// Load always restarts at HOLD-1; it stops at zero rather than wrapping.
module decoder_hold_cnt
   import decoder_pkg::*;
#(
   parameter int HOLD = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic zero
);
   localparam int CW = cnt_width(HOLD);
   localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_n_pulse.sv
// Registered binary-to-one-hot decoder with valid/ready input and HOLD-cycle strobes.
// Optional out-of-range discard with err pulse: define DEC_RANGE_CHECK_EN.
//
// state      | meaning
// DEC_IDLE   | no line selected, ready for a code
// DEC_ACTIVE | one line held; ready again only in the last hold cycle
module decoder_n_pulse
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int OUT_N = 4,
   parameter int HOLD  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   decoder_n_pulse_if.slave bus
);
   dec_state_t       state;
   logic             zero;
   logic             accept;
   logic             range_ok;
   logic [OUT_N-1:0] y_dec;

`ifdef DEC_RANGE_CHECK_EN
   localparam logic [SEL_W:0] OUT_LIM = (SEL_W + 1)'(OUT_N);
   assign range_ok = ({1'b0, bus.sel} < OUT_LIM);
`else
   assign range_ok = 1'b1;
`endif

   // Gated by rst_n so ready drops immediately in reset yet is high on the first cycle after.
   assign bus.in_ready = rst_n & ((state == DEC_IDLE) | zero);
   assign bus.busy     = (state == DEC_ACTIVE);
   assign accept       = bus.in_valid & bus.in_ready;

   // Codes with no matching line decode to all-zero rather than wrapping.
   always_comb begin
      y_dec = '0;
      for (int k = 0; k < OUT_N; k++) begin
         if (bus.sel == SEL_W'(k)) y_dec[k] = 1'b1;
      end
   end

   decoder_hold_cnt #(.HOLD(HOLD)) u_hold_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept & range_ok),
      .en    (state == DEC_ACTIVE),
      .zero  (zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= DEC_IDLE;
         bus.y    <= '0;
         bus.done <= 1'b0;
`ifdef DEC_RANGE_CHECK_EN
         bus.err  <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
`ifdef DEC_RANGE_CHECK_EN
         bus.err  <= accept & ~range_ok;
`endif
         case (state)
            DEC_IDLE: begin
               if (accept && range_ok) begin
                  bus.y <= y_dec;
                  state <= DEC_ACTIVE;
               end
            end
            DEC_ACTIVE: begin
               if (zero) begin
                  bus.done <= 1'b1;
                  if (accept && range_ok) begin
                     bus.y <= y_dec;
                  end else begin
                     bus.y <= '0;
                     state <= DEC_IDLE;
                  end
               end
            end
            default: begin
               bus.y <= '0;
               state <= DEC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_n_pulse.sv
// Directed bench for decoder_n_pulse: three configurations, vector tables plus reset sequences.
// Build with or without DEC_RANGE_CHECK_EN; expectations follow the macro.
module tb_decoder_n_pulse;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decoder_n_pulse_if #(.SEL_W(2), .OUT_N(4)) if_a ();
   decoder_n_pulse_if #(.SEL_W(2), .OUT_N(4)) if_b ();
   decoder_n_pulse_if #(.SEL_W(3), .OUT_N(6)) if_c ();

   decoder_n_pulse #(.SEL_W(2), .OUT_N(4), .HOLD(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   decoder_n_pulse #(.SEL_W(2), .OUT_N(4), .HOLD(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   decoder_n_pulse #(.SEL_W(3), .OUT_N(6), .HOLD(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   typedef struct {
      logic       valid;
      logic [2:0] sel;
      logic [7:0] y;
      logic       ready;
      logic       busy;
      logic       done;
      logic       err;
   } vec_t;

   vec_t va[$];
   vec_t vb[$];
   vec_t vc[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [7:0] y,
                               input logic r, input logic b, input logic d, input logic e);
      vec_t t;
      t.valid = v; t.sel = s; t.y = y; t.ready = r; t.busy = b; t.done = d; t.err = e;
      return t;
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int d, input int idx, input vec_t v);
      logic [7:0] ay;
      logic       ar, ab, ad, ae;
      string      tag;
      ae = 1'b0;
      case (d)
         0: begin if_a.in_valid = v.valid; if_a.sel = v.sel[1:0]; tag = "a"; end
         1: begin if_b.in_valid = v.valid; if_b.sel = v.sel[1:0]; tag = "b"; end
         default: begin if_c.in_valid = v.valid; if_c.sel = v.sel; tag = "c"; end
      endcase
      step();
      case (d)
         0: begin ay = {4'b0, if_a.y}; ar = if_a.in_ready; ab = if_a.busy; ad = if_a.done; end
         1: begin ay = {4'b0, if_b.y}; ar = if_b.in_ready; ab = if_b.busy; ad = if_b.done; end
         default: begin
            ay = {2'b0, if_c.y}; ar = if_c.in_ready; ab = if_c.busy; ad = if_c.done;
`ifdef DEC_RANGE_CHECK_EN
            ae = if_c.err;
`endif
         end
      endcase
      check($sformatf("%s[%0d] y", tag, idx), ay, v.y);
      check($sformatf("%s[%0d] in_ready", tag, idx), {7'b0, ar}, {7'b0, v.ready});
      check($sformatf("%s[%0d] busy", tag, idx), {7'b0, ab}, {7'b0, v.busy});
      check($sformatf("%s[%0d] done", tag, idx), {7'b0, ad}, {7'b0, v.done});
`ifdef DEC_RANGE_CHECK_EN
      if (d == 2) check($sformatf("%s[%0d] err", tag, idx), {7'b0, ae}, {7'b0, v.err});
`else
      if (ae) check($sformatf("%s[%0d] err", tag, idx), {7'b0, ae}, 8'h00);
`endif
   endtask

   initial begin
      if_a.in_valid = 1'b0; if_a.sel = '0;
      if_b.in_valid = 1'b0; if_b.sel = '0;
      if_c.in_valid = 1'b0; if_c.sel = '0;

      // HOLD=3: single code, ignored codes while busy, back-to-back in the last hold cycle.
      va.push_back(mk(1, 2, 8'h04, 0, 1, 0, 0));
      va.push_back(mk(0, 0, 8'h04, 0, 1, 0, 0));
      va.push_back(mk(0, 0, 8'h04, 1, 1, 0, 0));
      va.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
      va.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));
      va.push_back(mk(1, 3, 8'h08, 0, 1, 0, 0));
      va.push_back(mk(1, 0, 8'h08, 0, 1, 0, 0));
      va.push_back(mk(1, 1, 8'h08, 1, 1, 0, 0));
      va.push_back(mk(1, 1, 8'h02, 0, 1, 1, 0));
      va.push_back(mk(0, 0, 8'h02, 0, 1, 0, 0));
      va.push_back(mk(0, 0, 8'h02, 1, 1, 0, 0));
      va.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
      va.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));

      // HOLD=1: one code per cycle.
      vb.push_back(mk(1, 0, 8'h01, 1, 1, 0, 0));
      vb.push_back(mk(1, 1, 8'h02, 1, 1, 1, 0));
      vb.push_back(mk(1, 2, 8'h04, 1, 1, 1, 0));
      vb.push_back(mk(1, 3, 8'h08, 1, 1, 1, 0));
      vb.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
      vb.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));

      // SEL_W=3, OUT_N=6, HOLD=2: out-of-range code 7 from idle and from the last hold cycle.
`ifdef DEC_RANGE_CHECK_EN
      vc.push_back(mk(1, 7, 8'h00, 1, 0, 0, 1));
      vc.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));
      vc.push_back(mk(1, 5, 8'h20, 0, 1, 0, 0));
      vc.push_back(mk(1, 7, 8'h20, 1, 1, 0, 0));
      vc.push_back(mk(1, 7, 8'h00, 1, 0, 1, 1));
      vc.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));
`else
      vc.push_back(mk(1, 7, 8'h00, 0, 1, 0, 0));
      vc.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0));
      vc.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
      vc.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));
      vc.push_back(mk(1, 5, 8'h20, 0, 1, 0, 0));
      vc.push_back(mk(1, 7, 8'h20, 1, 1, 0, 0));
      vc.push_back(mk(1, 7, 8'h00, 0, 1, 1, 0));
      vc.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0));
      vc.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
      vc.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));
`endif

      // Reset state, with clock edges passing while held.
      #2;
      check("rst y", {4'b0, if_a.y}, 8'h00);
      check("rst in_ready", {7'b0, if_a.in_ready}, 8'h00);
      check("rst busy", {7'b0, if_a.busy}, 8'h00);
      check("rst done", {7'b0, if_a.done}, 8'h00);
      step();
      step();
      check("rst c in_ready", {7'b0, if_c.in_ready}, 8'h00);
      rst_n = 1'b1;
      #1;
      check("release a in_ready", {7'b0, if_a.in_ready}, 8'h01);
      check("release c in_ready", {7'b0, if_c.in_ready}, 8'h01);

      for (int i = 0; i < va.size(); i++) run_vec(0, i, va[i]);
      if_a.in_valid = 1'b0;
      for (int i = 0; i < vb.size(); i++) run_vec(1, i, vb[i]);
      if_b.in_valid = 1'b0;
      for (int i = 0; i < vc.size(); i++) run_vec(2, i, vc[i]);
      if_c.in_valid = 1'b0;

      // Reset in the middle of a hold: immediate clear, no done afterwards.
      if_a.in_valid = 1'b1; if_a.sel = 2'd1;
      step();
      if_a.in_valid = 1'b0;
      check("mid y before rst", {4'b0, if_a.y}, 8'h02);
      check("mid busy before rst", {7'b0, if_a.busy}, 8'h01);
      rst_n = 1'b0;
      #1;
      check("mid rst y", {4'b0, if_a.y}, 8'h00);
      check("mid rst busy", {7'b0, if_a.busy}, 8'h00);
      check("mid rst in_ready", {7'b0, if_a.in_ready}, 8'h00);
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("post rst in_ready", {7'b0, if_a.in_ready}, 8'h01);
      step();
      check("post rst done 1", {7'b0, if_a.done}, 8'h00);
      check("post rst y", {4'b0, if_a.y}, 8'h00);
      step();
      check("post rst done 2", {7'b0, if_a.done}, 8'h00);
      if_a.in_valid = 1'b1; if_a.sel = 2'd0;
      step();
      if_a.in_valid = 1'b0;
      check("post rst decode y", {4'b0, if_a.y}, 8'h01);
      check("post rst decode ready", {7'b0, if_a.in_ready}, 8'h00);
      step();
      step();
      check("post rst last ready", {7'b0, if_a.in_ready}, 8'h01);
      check("post rst last y", {4'b0, if_a.y}, 8'h01);
      step();
      check("post rst done", {7'b0, if_a.done}, 8'h01);
      check("post rst y cleared", {4'b0, if_a.y}, 8'h00);
      step();
      check("post rst done clear", {7'b0, if_a.done}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
